// File: rtl/mvm_pkg.sv
// mvm_pkg: shared defaults and read-sequencer state type for the matrix-vector multiplier
package mvm_pkg;
  localparam int MVM_DEPTH      = 8;
  localparam int MVM_DATA_WIDTH = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CLR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } mvm_rd_state_t;
endpackage

// File: rtl/b_skew_line.sv
// b_skew_line: DEPTH-1 stage register chain giving each lane its B operand one cycle later than the previous lane
module b_skew_line #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] taps [DEPTH-1]
);
  logic [DATA_WIDTH-1:0] stage_q [DEPTH-1];
  // shift B one lane further every cycle; reset empties the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH-1; j++) stage_q[j] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int j = 1; j < DEPTH-1; j++) stage_q[j] <= stage_q[j-1];
    end
  end
  assign taps = stage_q;
endmodule

// File: rtl/mvm_fifo_reader.sv
// mvm_fifo_reader: drains full A/B FIFOs in a systolic skew and drives MAC enable/clear
module mvm_fifo_reader
  import mvm_pkg::*;
#(
  parameter int DEPTH      = MVM_DEPTH,
  parameter int DATA_WIDTH = MVM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DEPTH-1:0]      a_full,
  input  logic                  b_full,
  input  logic [DATA_WIDTH-1:0] b_fifo_out,
  output logic [DEPTH-1:0]      a_rden,
  output logic                  b_rden,
  output logic [DATA_WIDTH-1:0] b_lane [DEPTH],
  output logic [DEPTH-1:0]      mac_en,
  output logic                  mac_clr,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(2*DEPTH-1);
  localparam logic [CW-1:0] C_LAST  = CW'(2*DEPTH-2);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  mvm_rd_state_t state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [DEPTH-1:0] mac_en_q;
  logic [DATA_WIDTH-1:0] taps [DEPTH-1];
  // state, step counter and read-latency-aligned MAC enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      mac_en_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      mac_en_q <= a_rden;
    end
  end
  // pass sequencing: wait for full FIFOs, clear, run 2*DEPTH-1 steps, flush, report
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ARM;
      S_ARM:   if (&a_full && b_full) state_d = S_CLR;
      S_CLR:   begin
        state_d = S_RUN;
        c_d     = '0;
      end
      S_RUN:   if (c_q == C_LAST) state_d = S_FLUSH;
               else c_d = c_q + 1'b1;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign b_rden  = (state_q == S_RUN) && (c_q < C_DEPTH);
  assign mac_en  = mac_en_q;
  assign mac_clr = state_q == S_CLR;
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign b_lane[0] = b_fifo_out;
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    localparam logic [CW-1:0] LO = CW'(i);
    localparam logic [CW-1:0] HI = CW'(i + DEPTH);
    assign a_rden[i] = (state_q == S_RUN) && (c_q >= LO) && (c_q < HI);
    if (i > 0) begin : g_tap
      assign b_lane[i] = taps[i-1];
    end
  end
  b_skew_line #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (b_fifo_out),
    .taps (taps)
  );
endmodule

// File: tb/tb_mvm_fifo_reader.sv
// tb_mvm_fifo_reader: FIFO/MAC harness plus timeline model checking the read sequencer every cycle
module tb_mvm_fifo_reader;
  localparam int D = 8;
  localparam int W = 8;
  logic clk = 0, rst_n = 1, start = 0;
  logic [D-1:0] a_full = '0;
  logic b_full = 0;
  logic [W-1:0] b_fifo_out = '0;
  logic [D-1:0] a_rden, mac_en;
  logic b_rden, mac_clr, busy, done;
  logic [W-1:0] b_lane [D];

  mvm_fifo_reader #(.DEPTH(D), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_full(a_full), .b_full(b_full),
    .b_fifo_out(b_fifo_out), .a_rden(a_rden), .b_rden(b_rden), .b_lane(b_lane),
    .mac_en(mac_en), .mac_clr(mac_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // FIFO harness: one-cycle read latency, refill on request, reset empties everything
  logic [W-1:0] aq [D][$];
  logic [W-1:0] bq [$];
  logic [W-1:0] a_dout [D];
  int a_mat [D][D];
  int b_vec [D];
  bit fill_req = 0, b_hold = 0;
  int a_reads [D] = '{default: 0};
  int b_reads = 0, underflow = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin aq[i].delete(); a_dout[i] <= '0; end
      bq.delete();
      b_fifo_out <= '0;
      a_full <= '0;
      b_full <= 0;
    end else begin
      for (int i = 0; i < D; i++)
        if (a_rden[i]) begin
          if (aq[i].size() == 0) underflow++;
          else begin a_dout[i] <= aq[i].pop_front(); a_reads[i]++; end
        end
      if (b_rden) begin
        if (bq.size() == 0) underflow++;
        else begin b_fifo_out <= bq.pop_front(); b_reads++; end
      end
      if (fill_req) begin
        for (int i = 0; i < D; i++)
          for (int k = 0; k < D; k++) aq[i].push_back(W'(a_mat[i][k]));
        for (int k = 0; k < D; k++) bq.push_back(W'(b_vec[k]));
      end
      for (int i = 0; i < D; i++) a_full[i] <= aq[i].size() == D;
      b_full <= bq.size() == D && !b_hold;
    end
  end

  // MAC array harness
  int acc [D];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < D; i++) acc[i] <= 0;
    else for (int i = 0; i < D; i++)
      if (mac_clr) acc[i] <= 0;
      else if (mac_en[i]) acc[i] <= acc[i] + int'(a_dout[i]) * int'(b_lane[i]);
  end

  // timeline model: mode 0 idle, 1 waiting for full, 2 in pass at offset m_k (1=CLR .. 2D+2=DONE)
  int m_mode = 0, m_k = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin m_mode <= 0; m_k <= 0; end
    else if (m_mode == 0) begin if (start) m_mode <= 1; end
    else if (m_mode == 1) begin if (&a_full && b_full) begin m_mode <= 2; m_k <= 1; end end
    else if (m_k == 2*D+2) m_mode <= 0;
    else m_k <= m_k + 1;
  end
  function automatic bit lane_rd(int k, int i);
    return k >= 2 && k <= 2*D && k-2 >= i && k-2 < i+D;
  endfunction

  int last_low = 0, n_done = 0, n_clr = 0;
  logic [W-1:0] blog [4096];
  logic [D-1:0] e_ar, e_me;
  logic [W-1:0] e_bl;
  always @(negedge clk) begin
    if (cyc < 4096) blog[cyc] = b_fifo_out;
    if (!rst_n) last_low = cyc;
    if (done) n_done++;
    if (mac_clr) n_clr++;
    for (int i = 0; i < D; i++) begin
      e_ar[i] = m_mode == 2 && lane_rd(m_k, i);
      e_me[i] = m_mode == 2 && lane_rd(m_k-1, i);
    end
    chk("busy", busy, m_mode != 0);
    chk("mac_clr", mac_clr, m_mode == 2 && m_k == 1);
    chk("done", done, m_mode == 2 && m_k == 2*D+2);
    chk("b_rden", b_rden, m_mode == 2 && m_k >= 2 && m_k-2 < D);
    chk("a_rden", a_rden, e_ar);
    chk("mac_en", mac_en, e_me);
    for (int i = 0; i < D; i++) begin
      e_bl = (cyc - i >= last_low && cyc - i < 4096) ? blog[cyc-i] : '0;
      chk($sformatf("b_lane%0d", i), b_lane[i], e_bl);
    end
  end

  task automatic load(int mode);
    for (int i = 0; i < D; i++) begin
      for (int k = 0; k < D; k++)
        a_mat[i][k] = mode == 0 ? 1 : mode == 1 ? i+1 : (i*3+k)%7+1;
      b_vec[i] = mode == 0 ? 1 : mode == 1 ? i+1 : i%5+2;
    end
  endtask
  task automatic fill();
    @(negedge clk); fill_req = 1;
    @(negedge clk); fill_req = 0;
    @(negedge clk);
  endtask
  task automatic pulse_start(output int s);
    @(negedge clk); s = cyc; start = 1;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_done(output int dc);
    dc = -1;
    for (int n = 0; n < 80 && dc < 0; n++) begin
      @(negedge clk);
      if (done) dc = cyc;
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask
  task automatic check_pass(int dgot, int dexp, int b0, int ar0 [D]);
    int e;
    chk("done_cycle", dgot, dexp);
    chk("b_reads", b_reads - b0, D);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("a_reads%0d", i), a_reads[i] - ar0[i], D);
      e = 0;
      for (int k = 0; k < D; k++) e += a_mat[i][k] * b_vec[k];
      chk($sformatf("acc%0d", i), acc[i], e);
    end
  endtask

  initial begin
    int s, d, b0, c0, dn0;
    int ar0 [D];
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_lane3", b_lane[3], 0);
    #2 rst_n = 1;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rden", {a_rden, b_rden}, 0);

    // all-ones pass
    load(0); fill();
    b0 = b_reads; ar0 = a_reads; c0 = n_clr;
    pulse_start(s); wait_done(d);
    check_pass(d, s + 19, b0, ar0);
    chk("clr_pulses", n_clr - c0, 1);
    chk("acc_lit_ones", acc[5], 8);
    repeat (3) @(negedge clk);

    // row i = i+1, B = 1..8, skew pins, start during RUN ignored
    load(1); fill();
    b0 = b_reads; ar0 = a_reads; dn0 = n_done;
    pulse_start(s);
    repeat (5) @(negedge clk);
    chk("pin_a_rden_c3", a_rden, 8'h0F);
    chk("pin_mac_en_c3", mac_en, 8'h07);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    chk("pin_a_rden_c10", a_rden, 8'hF8);
    chk("pin_mac_en_c10", mac_en, 8'hFC);
    chk("pin_b_rden_c10", b_rden, 0);
    wait_done(d);
    check_pass(d, s + 19, b0, ar0);
    chk("acc_lit_row0", acc[0], 36);
    chk("acc_lit_row7", acc[7], 288);
    repeat (25) @(negedge clk);
    chk("single_done", n_done - dn0, 1);
    chk("idle_after", busy, 0);

    // B not full: hold in ARM, then release
    b_hold = 1; load(1); fill();
    b0 = b_reads; ar0 = a_reads;
    pulse_start(s);
    repeat (5) @(negedge clk);
    chk("arm_busy", busy, 1);
    chk("arm_rden", {a_rden, b_rden}, 0);
    b_hold = 0;
    wait_done(d);
    check_pass(d, s + 6 + 19, b0, ar0);

    // reset at RUN c=4, then a fresh pass
    repeat (3) @(negedge clk);
    load(2); fill();
    pulse_start(s);
    repeat (6) @(negedge clk);
    chk("pre_rst_a_rden", a_rden, 8'h1F);
    #2 rst_n = 0;
    #1;
    chk("rst_a_rden", a_rden, 0);
    chk("rst_b_rden", b_rden, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_busy_mid", busy, 0);
    @(negedge clk);
    #2 rst_n = 1;
    load(2); fill();
    b0 = b_reads; ar0 = a_reads;
    pulse_start(s); wait_done(d);
    check_pass(d, s + 19, b0, ar0);
    repeat (3) @(negedge clk);
    chk("underflow", underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/mvm_fifo_reader.md
# mvm_fifo_reader

Read-side sequencer for the matrix-vector multiplier's input FIFOs. Once all eight A-row FIFOs and the B FIFO are full, it drains them in a systolic skew: lane i starts reading i cycles after lane 0. It forwards B through a per-lane delay line and drives MAC enable and clear, so that `out[i]` accumulates row i · B. It sits between the A/B FIFOs and the MAC array inside `mat_vec_mult` and replaces externally driven `a_rden`/`b_rden`.

## Interface
- `DEPTH`, 8, FIFO depth, lane count and vector length (square matrix).
- `DATA_WIDTH`, 8, element width of A and B.

- `clk` in 1, single clock; all logic on posedge.
- `rst_n` in 1, asynchronous active-low reset.
- `start` in 1, request one pass; sampled only in IDLE.
- `a_full` in [DEPTH-1:0], per-lane A FIFO full flags.
- `b_full` in 1, B FIFO full flag.
- `b_fifo_out` in DATA_WIDTH, B FIFO read data, valid the cycle after `b_rden`.
- `a_rden` out [DEPTH-1:0], per-lane A FIFO read enables.
- `b_rden` out 1, B FIFO read enable.
- `b_lane` out DATA_WIDTH × [DEPTH-1:0] (unpacked), skewed B operand per lane.
- `mac_en` out [DEPTH-1:0], per-lane MAC accumulate enable.
- `mac_clr` out 1, one-cycle synchronous clear of all MAC accumulators.
- `busy` out 1, high in any state other than IDLE.
- `done` out 1, one-cycle pulse at the end of a pass.

## Operation
- States: IDLE, ARM, CLR, RUN, FLUSH, DONE.
  - IDLE: on `start`, go to ARM. `start` in any other state is ignored.
  - ARM: wait until `&a_full && b_full`, then go to CLR.
  - CLR: `mac_clr`=1 for exactly this cycle. Go to RUN and set step counter `c`=0.
  - RUN: `c` counts 0 to 2·DEPTH−2. At `c`=2·DEPTH−2, go to FLUSH.
  - FLUSH: one cycle. Go to DONE.
  - DONE: `done`=1 for this cycle. Go to IDLE.
- Read enables are decoded combinationally from registered state and `c`:
  - `b_rden` = RUN && `c` < DEPTH.
  - `a_rden[i]` = RUN && `c` ≥ i && `c` < i+DEPTH.
- `mac_en[i]` is `a_rden[i]` registered one cycle, which aligns it with FIFO read latency.
- B delay line:
  - `b_lane[0]` = `b_fifo_out` (combinational pass-through).
  - `b_lane[i]` = `b_lane[i−1]` registered, for i ≥ 1.
  - Result: A element k of lane i and B element k meet at cycle c=i+k+1.
- `c` width is `$clog2(2*DEPTH-1)`. There is no wrap: `c` is reloaded to 0 only in CLR.
- The FIFOs are never read when empty, because the pass starts only when all are full and performs exactly DEPTH reads per FIFO. Writes during RUN are the writer's responsibility and are not checked.

## Timing
- Reset state:
  - State IDLE, `c`=0.
  - `mac_en`=0 and `b_lane[1..DEPTH-1]`=0.
  - All outputs are 0, except `b_lane[0]`, which follows `b_fifo_out`.
- If the full condition holds when ARM is entered, ARM lasts 1 cycle.
- From the ARM cycle t in which the full condition is true:
  - CLR at t+1.
  - RUN from t+2 to t+2·DEPTH.
  - FLUSH at t+2·DEPTH+1.
  - DONE at t+2·DEPTH+2.
- For DEPTH=8, `start` in IDLE at cycle s with the FIFOs already full gives `done` at s+19.
- Last `mac_en[DEPTH-1]` falls in FLUSH. `out[]` is final by the DONE cycle.
- Reset asserted mid-pass returns the block to IDLE immediately and clears all registered outputs. A partial FIFO drain is not recovered; the FIFOs must be reset as well.

## Structure
- Shared package `mvm_pkg`:
  - `mvm_rd_state_t` enum for the six states.
  - Default `DEPTH` and `DATA_WIDTH` localparams shared with `mat_vec_mult`.
- One sub-module, `b_skew_line`: a parameterized DEPTH−1-stage register chain with async reset, producing `b_lane[1..DEPTH-1]`.

## Test plan
- Reset, then hold `start`=0 → all outputs 0 and `busy`=0 indefinitely.
- Full FIFOs (A all 1, B all 1), pulse `start` → `mac_clr` 1 cycle, `done` 19 cycles later, each `out[i]`=8.
- A row i = i+1, B = {1..8} → `out[i]` = (i+1)·36. Also check the `a_rden`/`mac_en` diagonal skew pattern cycle by cycle.
- `start` with `b_full`=0 → block holds in ARM with no `rden` asserted. Raise `b_full` 5 cycles later → pass proceeds and `done` arrives 19 cycles after ARM entry + 5.
- `start` pulsed again during RUN → ignored. Exactly DEPTH reads per FIFO, and one `done`.
- `rst_n` low at RUN `c`=4 → same cycle all `rden`/`mac_en`/`busy` return to 0 and state is IDLE. A new pass after refill produces correct results.
